multicycle_core: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle processor datapath.
- Executes one 32-bit instruction at a time through a FETCH/DECODE/EXEC/MEM/WB state machine, using a single ALU, a register file and a synchronous-read data memory.
- Instruction memory is external and read combinationally, so the bench supplies programs.
- Adds conditional branch, jump, halt, run gating and a retired-instruction counter.

---
 rtl/multicycle_core.sv | 185 ++++++++++++++++++
 tb/tb_multicycle_core.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_core.sv
// Multi-cycle 32-bit-instruction core: FETCH/DECODE/EXEC/MEM/WB sequencing over one ALU,
// a 32-entry register file and a synchronous-read data memory; external combinational imem.
module multicycle_core #(
  parameter int DATA_W  = 32,
  parameter int PC_W    = 8,
  parameter int DMEM_AW = 7
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              run,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [31:0]       imem_data,
  output logic              reg_we,
  output logic [DATA_W-1:0] reg_write_data,
  output logic              halted,
  output logic [31:0]       retired
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED
  } state_t;

  localparam logic [3:0] OP_ALUR  = 4'd0;
  localparam logic [3:0] OP_ALUI  = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_STORE = 4'd3;
  localparam logic [3:0] OP_BEQ   = 4'd4;
  localparam logic [3:0] OP_JUMP  = 4'd5;
  localparam logic [3:0] OP_HALT  = 4'd15;
  localparam int SHW = (DATA_W > 32) ? 6 : 5;

  state_t state, state_nxt;

  logic        [PC_W-1:0]   pc;
  logic        [31:0]       ir_p0;
  logic signed [DATA_W-1:0] a_p1, b_p1, imm_p1;
  logic        [PC_W-1:0]   immpc_p1;
  logic signed [DATA_W-1:0] alu_p2;
  logic signed [DATA_W-1:0] mdr_p3;
  logic signed [DATA_W-1:0] wd_hold;
  logic signed [DATA_W-1:0] wb_val;
  logic signed [DATA_W-1:0] op2;
  logic        [2:0]        fsel;

  logic signed [DATA_W-1:0] rf   [0:31];
  logic        [DATA_W-1:0] dmem [0:(1<<DMEM_AW)-1];

  logic [3:0] op;
  logic [2:0] f;
  logic [4:0] rd, rs, rt;

  assign op = ir_p0[31:28];
  assign f  = ir_p0[27:25];
  assign rd = ir_p0[24:20];
  assign rs = ir_p0[19:15];
  assign rt = ir_p0[14:10];

  function automatic logic signed [DATA_W-1:0] alu(
    input logic        [2:0]        fn,
    input logic signed [DATA_W-1:0] x,
    input logic signed [DATA_W-1:0] y
  );
    logic [SHW-1:0] sh;
    sh = y[SHW-1:0];
    case (fn)
      3'd0:    alu = x + y;
      3'd1:    alu = x - y;
      3'd2:    alu = x & y;
      3'd3:    alu = x | y;
      3'd4:    alu = x ^ y;
      3'd5:    alu = x << sh;
      3'd6:    alu = $signed($unsigned(x) >> sh);
      default: alu = {{(DATA_W-1){1'b0}}, (x < y)};
    endcase
  endfunction

  assign imem_addr = pc;
  assign op2  = (op == OP_ALUR) ? b_p1 : imm_p1;
  assign fsel = (op == OP_ALUR || op == OP_ALUI) ? f : 3'd0;
  assign wb_val = (op == OP_LOAD) ? mdr_p3 : alu_p2;
  assign reg_we = (state == S_WB) && (rd != 5'd0);
  assign reg_write_data = reg_we ? wb_val : wd_hold;

  always_ff @(posedge CLK) begin
    if (RST) state <= S_FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (run) state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        case (op)
          OP_ALUR, OP_ALUI:  state_nxt = S_WB;
          OP_LOAD, OP_STORE: state_nxt = S_MEM;
          OP_HALT:           state_nxt = S_HALTED;
          default:           state_nxt = S_FETCH;
        endcase
      end
      S_MEM:    state_nxt = (op == OP_LOAD) ? S_WB : S_FETCH;
      S_WB:     state_nxt = S_FETCH;
      S_HALTED: state_nxt = S_HALTED;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // Control: pc, IR, retire/halt bookkeeping
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc      <= '0;
      ir_p0   <= '0;
      halted  <= 1'b0;
      retired <= '0;
      wd_hold <= '0;
    end else begin
      case (state)
        S_FETCH: if (run) ir_p0 <= imem_data;
        S_EXEC: begin
          case (op)
            OP_ALUR, OP_ALUI, OP_LOAD, OP_STORE: ;
            OP_BEQ: begin
              pc      <= (a_p1 == b_p1) ? pc + PC_W'(1) + immpc_p1 : pc + PC_W'(1);
              retired <= retired + 32'd1;
            end
            OP_JUMP: begin
              pc      <= immpc_p1;
              retired <= retired + 32'd1;
            end
            OP_HALT: begin
              halted  <= 1'b1;
              retired <= retired + 32'd1;
            end
            default: begin
              pc      <= pc + PC_W'(1);
              retired <= retired + 32'd1;
            end
          endcase
        end
        S_MEM: begin
          if (op == OP_STORE) begin
            pc      <= pc + PC_W'(1);
            retired <= retired + 32'd1;
          end
        end
        S_WB: begin
          pc      <= pc + PC_W'(1);
          retired <= retired + 32'd1;
          if (reg_we) wd_hold <= wb_val;
        end
        default: ;
      endcase
    end
  end

  // Datapath: operand latch in DECODE, ALU result in EXEC
  always_ff @(posedge CLK) begin
    if (state == S_DECODE) begin
      a_p1     <= rf[rs];
      b_p1     <= (op == OP_ALUR) ? rf[rt] : rf[rd];
      imm_p1   <= DATA_W'($signed(ir_p0[14:0]));
      immpc_p1 <= PC_W'($signed(ir_p0[14:0]));
    end
    if (state == S_EXEC) alu_p2 <= alu(fsel, a_p1, op2);
  end

  // R0 is cleared on reset and never written, so it always reads zero
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (reg_we) begin
      rf[rd] <= wb_val;
    end
  end

  // Memory stage: synchronous read, data valid in the following WB cycle
  always_ff @(posedge CLK) begin
    if (state == S_MEM) begin
      if (op == OP_STORE && !RST) dmem[alu_p2[DMEM_AW-1:0]] <= b_p1;
      mdr_p3 <= $signed(dmem[alu_p2[DMEM_AW-1:0]]);
    end
  end

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: hand-assembled programs with per-instruction latency,
// write-back value, pc and retired-count expectations.
module tb_multicycle_core;

  logic        CLK;
  logic        RST;
  logic        run;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        reg_we;
  logic [31:0] reg_write_data;
  logic        halted;
  logic [31:0] retired;

  logic [31:0] imem [0:255];
  assign imem_data = imem[imem_addr];

  multicycle_core #(.DATA_W(32), .PC_W(8), .DMEM_AW(7)) dut (
    .CLK(CLK), .RST(RST), .run(run),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .reg_we(reg_we), .reg_write_data(reg_write_data),
    .halted(halted), .retired(retired)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_chk  = 0;
  int n_pass = 0;
  int exp_ret = 0;
  logic [31:0] last_wd = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] enc(input int op, input int f, input int rd, input int rs,
                                      input int imm);
    enc = {op[3:0], f[2:0], rd[4:0], rs[4:0], imm[14:0]};
  endfunction

  // Starts at the negedge of the instruction's FETCH cycle, ends at the next FETCH
  task automatic exec(input string tag, input int n, input bit exp_we, input logic [31:0] exp_wd,
                      input int exp_pc);
    int we_at;
    logic [31:0] wd_seen;
    we_at = 0;
    wd_seen = '0;
    for (int c = 1; c <= n; c++) begin
      if (reg_we) begin
        we_at = (we_at == 0) ? c : -1;
        wd_seen = reg_write_data;
      end
      @(negedge CLK);
    end
    exp_ret++;
    chk({tag, "_we_cycle"}, 64'(we_at), exp_we ? 64'(n) : 64'd0);
    if (exp_we) begin
      chk({tag, "_wdata"}, wd_seen, exp_wd);
      last_wd = exp_wd;
    end else begin
      chk({tag, "_wdata_hold"}, reg_write_data, last_wd);
    end
    chk({tag, "_pc"}, imem_addr, 64'(exp_pc[7:0]));
    chk({tag, "_retired"}, retired, 64'(exp_ret));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int we_count;
    for (int i = 0; i < 256; i++) imem[i] = 32'h6000_0000;
    imem[0]   = enc(1, 0, 1, 0, 5);
    imem[1]   = enc(1, 0, 2, 0, -3);
    imem[2]   = enc(0, 0, 3, 1, 2 << 10);
    imem[3]   = enc(3, 0, 3, 0, 10);
    imem[4]   = enc(2, 0, 4, 0, 10);
    imem[5]   = enc(0, 1, 5, 4, 1 << 10);
    imem[6]   = enc(4, 0, 1, 1, 2);
    imem[7]   = enc(1, 0, 7, 0, 99);
    imem[8]   = enc(1, 0, 7, 0, 99);
    imem[9]   = enc(4, 0, 1, 2, 5);
    imem[10]  = enc(1, 0, 0, 0, 7);
    imem[11]  = enc(0, 0, 6, 0, 0);
    imem[12]  = enc(1, 0, 8, 0, -1);
    imem[13]  = enc(1, 0, 9, 0, 1);
    imem[14]  = enc(0, 7, 10, 8, 9 << 10);
    imem[15]  = enc(1, 0, 11, 0, 1);
    imem[16]  = enc(1, 5, 11, 11, 31);
    imem[17]  = enc(1, 6, 12, 11, 31);
    imem[18]  = enc(0, 7, 13, 9, 8 << 10);
    imem[19]  = enc(1, 3, 14, 1, 32'h30);
    imem[20]  = enc(0, 4, 15, 14, 1 << 10);
    imem[21]  = enc(5, 0, 0, 0, 32'hFF);

    RST = 1'b1;
    run = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_pc", imem_addr, 0);
    chk("rst_halted", halted, 0);
    chk("rst_retired", retired, 0);
    chk("rst_reg_we", reg_we, 0);
    chk("rst_wdata", reg_write_data, 0);
    RST = 1'b0;

    exec("addi_r1", 4, 1, 32'd5, 1);
    exec("addi_r2", 4, 1, 32'hFFFF_FFFD, 2);
    exec("add_r3", 4, 1, 32'd2, 3);
    exec("store", 4, 0, 32'd0, 4);
    exec("load_r4", 5, 1, 32'd2, 5);
    exec("sub_r5", 4, 1, 32'hFFFF_FFFD, 6);
    exec("beq_taken", 3, 0, 32'd0, 9);
    exec("beq_not", 3, 0, 32'd0, 10);
    exec("addi_r0", 4, 0, 32'd0, 11);
    exec("add_r6_r0", 4, 1, 32'd0, 12);
    exec("addi_r8", 4, 1, 32'hFFFF_FFFF, 13);
    exec("addi_r9", 4, 1, 32'd1, 14);
    exec("slt_lt", 4, 1, 32'd1, 15);
    exec("addi_r11", 4, 1, 32'd1, 16);
    exec("slli", 4, 1, 32'h8000_0000, 17);
    exec("srli", 4, 1, 32'd1, 18);
    exec("slt_ge", 4, 1, 32'd0, 19);
    exec("ori", 4, 1, 32'h35, 20);
    exec("xor", 4, 1, 32'h30, 21);
    exec("jump_ff", 3, 0, 32'd0, 255);
    exec("nop_wrap", 3, 0, 32'd0, 0);

    run = 1'b0;
    we_count = 0;
    for (int i = 0; i < 4; i++) begin
      if (reg_we) we_count++;
      @(negedge CLK);
    end
    chk("idle_pc", imem_addr, 0);
    chk("idle_retired", retired, 64'(exp_ret));
    chk("idle_we", 64'(we_count), 0);

    imem[0] = enc(2, 0, 4, 0, 10);
    imem[1] = enc(15, 0, 0, 0, 0);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    run = 1'b1;
    exp_ret = 0;
    last_wd = '0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("abort_we", reg_we, 0);
    chk("abort_pc", imem_addr, 0);
    chk("abort_retired", retired, 0);
    chk("abort_wdata", reg_write_data, 0);
    RST = 1'b0;

    exec("load_retained", 5, 1, 32'd2, 1);
    exec("halt", 3, 0, 32'd0, 1);
    chk("halt_flag", halted, 1);

    we_count = 0;
    for (int i = 0; i < 20; i++) begin
      run = i[0];
      if (reg_we) we_count++;
      @(negedge CLK);
    end
    chk("frozen_pc", imem_addr, 1);
    chk("frozen_retired", retired, 2);
    chk("frozen_halted", halted, 1);
    chk("frozen_we", 64'(we_count), 0);

    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("exit_halted", halted, 0);
    chk("exit_retired", retired, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
